cfg_addr_seq_6bit: RTL and testbench
====================================

# cfg_addr_seq_6bit

Configuration-address sequencer that sits directly upstream of the 6-bit carry-lookahead adder in the Zilla fabric configuration path. It holds the current 6-bit frame address and stride and drives them into the adder as operands. It consumes the adder's sum as the next address. It issues a valid/ready write stream of `count` addresses starting at `base` and stepping by `stride` modulo 64, then pulses `done`.

## Interface
- Parameters: none. All address, stride and count widths are fixed at 6 bits to match the downstream adder.
- `clk` input 1 — single clock; all state updates on the rising edge.
- `rst` input 1 — asynchronous, active-high reset.
- `start` input 1 — request a new sequence; sampled only in IDLE.
- `base` input 6 — first address; captured on an accepted start.
- `stride` input 6 — address increment; captured on an accepted start.
- `count` input 6 — number of writes; captured on an accepted start. 0 means 64.
- `add_a` output 6 — adder operand A, equal to the current address register.
- `add_b` output 6 — adder operand B, equal to the captured stride register.
- `add_sum` input 6 — adder result, `(add_a + add_b) mod 64`, purely combinational.
- `wr_valid` output 1 — write address is valid.
- `wr_addr` output 6 — write address, equal to the current address register.
- `wr_ready` input 1 — the consumer accepts the beat when `wr_valid & wr_ready`.
- `busy` output 1 — high while in RUN.
- `done` output 1 — one-cycle pulse after the last beat is accepted.

## Operation
- FSM states: IDLE, RUN, DONE.
- **IDLE**
  - `wr_valid`=0, `busy`=0, `done`=0.
  - If `start`=1: `addr`←`base`, `stride_r`←`stride`, `rem`←`count` (7-bit, 0 maps to 64). Next state RUN.
- **RUN**
  - `wr_valid`=1, `busy`=1, `wr_addr`=`addr`.
  - On accept (`wr_valid & wr_ready`): `addr`←`add_sum` and `rem`←`rem`−1.
  - If `rem`==1 at accept, next state is DONE; otherwise stay in RUN.
  - Without accept, `addr` and `rem` hold and `wr_addr` stays stable. `wr_valid` never drops while in RUN.
- **DONE**
  - `done`=1, `wr_valid`=0, `busy`=0.
  - Next state is always IDLE. `start` is ignored in this state.
- `start` is ignored in RUN and DONE. Changes on `base`, `stride` or `count` outside an accepted start have no effect.
- Arithmetic: the address advance comes only from `add_sum`; the block contains no private adder. The address wraps modulo 64 and the carry out is discarded. Stride 0 is legal and repeats `base` `count` times.
- `add_a` and `add_b` are driven directly from registers, so there is no combinational path from any input to the adder operands.
- Reset (asynchronous, at any time including mid-RUN):
  - State returns to IDLE; `addr`, `stride_r` and `rem` clear to 0.
  - `wr_valid`, `busy`, `done`, `wr_addr`, `add_a` and `add_b` go to 0 immediately.
  - No partial sequence resumes after reset release; a new `start` is required.

## Timing
- `start` sampled in IDLE at edge N → `wr_valid`=1 and `wr_addr`=`base` from cycle N+1.
- Beat accepted at edge K → `wr_addr` equals the previous address plus `stride` from cycle K+1, giving one beat per cycle under continuous `wr_ready`.
- Last beat accepted at edge M → in cycle M+1, `done`=1 and `wr_valid`=0. IDLE is reached at M+2, which is the earliest cycle a new `start` is sampled.
- Minimum sequence length is `count`+2 cycles from the start edge to the return to IDLE, with `wr_ready` held high.
- Critical path: register → external adder → `addr` register. The block adds no logic after `add_sum` beyond a 2:1 hold mux.

## Test plan
- `base`=5, `stride`=3, `count`=4, `wr_ready`=1 → `wr_addr` 5, 8, 11, 14 on consecutive cycles; `done` pulses one cycle after 14 is accepted; exactly 4 beats.
- Wrap-around: `base`=62, `stride`=3, `count`=3 → `wr_addr` 62, 1, 4; `done` follows.
- Count zero: `base`=0, `stride`=1, `count`=0 → 64 beats, 0 through 63; `done` after the beat at 63 is accepted; no 65th beat.
- Backpressure: `base`=10, `stride`=2, `count`=3, with `wr_ready` low for 3 cycles on beat 2 → `wr_addr` holds at 12 with `wr_valid`=1; the sequence then continues 12, 14; total beats is 3.
- Ignored start: assert `start` with `base`=40 during RUN and during the DONE cycle → the sequence is unaffected and no new sequence begins until `start` is seen in IDLE.
- Reset mid-run: assert `rst` during beat 2 of a `count`=5 sequence → `wr_valid`, `busy`, `done` and `wr_addr` drop to 0 immediately. After release the block stays in IDLE with no beats until the next `start`.

Source files
------------

// File: rtl/cfg_addr_seq_6bit_if.sv
// Bundle shared by the sequencer, its external 6-bit adder and the write
// consumer. The sequencer side uses the master modport. The environment side
// (start source, adder, consumer) uses the slave modport.
interface cfg_addr_seq_6bit_if;
    logic       start;
    logic [5:0] base;
    logic [5:0] stride;
    logic [5:0] count;
    logic [5:0] add_a;
    logic [5:0] add_b;
    logic [5:0] add_sum;
    logic       wr_valid;
    logic [5:0] wr_addr;
    logic       wr_ready;
    logic       busy;
    logic       done;

    modport master (
        input  start, base, stride, count, add_sum, wr_ready,
        output add_a, add_b, wr_valid, wr_addr, busy, done
    );

    modport slave (
        output start, base, stride, count, add_sum, wr_ready,
        input  add_a, add_b, wr_valid, wr_addr, busy, done
    );
endinterface

// File: rtl/cfg_addr_seq_6bit.sv
// Configuration-address sequencer. It streams `count` frame addresses, from
// `base` and stepping by `stride` modulo 64, over a valid/ready write
// channel. A `count` of 0 means 64 addresses. Each address advance is
// produced by the external carry-lookahead adder. The sequencer feeds the
// adder its address and stride registers, then loads the returned sum.
// After the last accepted beat it pulses `done` for one cycle.
module cfg_addr_seq_6bit (
    input  logic                  clk,
    input  logic                  rst,
    cfg_addr_seq_6bit_if.master   bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_next_state;
    logic [5:0] r_addr;
    logic [5:0] r_stride;
    logic [6:0] r_rem;      // beats still to issue, 1..64 while running
    logic       w_start_acc;
    logic       w_accept;

    assign w_start_acc = (r_state == ST_IDLE) && bus.start;
    assign w_accept    = (r_state == ST_RUN) && bus.wr_ready;

    // The adder operands and write address come straight from registers, so
    // no input reaches the adder combinationally.
    assign bus.add_a   = r_addr;
    assign bus.add_b   = r_stride;
    assign bus.wr_addr = r_addr;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: clocked state uses non-blocking assignments so that every
        // register samples pre-edge values, whatever the evaluation order.
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: run until the beat that takes rem from 1 to 0
    always_comb begin
        // NOTE: the default assignment ahead of the case keeps every path
        // assigned, so no latch is inferred.
        w_next_state = r_state;
        unique case (r_state)
            ST_IDLE: if (bus.start) w_next_state = ST_RUN;
            ST_RUN:  if (w_accept && (r_rem == 7'd1)) w_next_state = ST_DONE;
            ST_DONE: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Output decode: Moore outputs, cleared immediately by an async reset
    always_comb begin
        bus.wr_valid = 1'b0;
        bus.busy     = 1'b0;
        bus.done     = 1'b0;
        unique case (r_state)
            ST_RUN: begin
                bus.wr_valid = 1'b1;
                bus.busy     = 1'b1;
            end
            ST_DONE: bus.done = 1'b1;
            default: ;
        endcase
    end

    // Datapath: capture operands on start, advance from the adder on accept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr   <= 6'd0;
            r_stride <= 6'd0;
            r_rem    <= 7'd0;
        end else if (w_start_acc) begin
            r_addr   <= bus.base;
            r_stride <= bus.stride;
            r_rem    <= (bus.count == 6'd0) ? 7'd64 : {1'b0, bus.count};
        end else if (w_accept) begin
            r_addr   <= bus.add_sum;
            r_rem    <= r_rem - 7'd1;
        end
    end

endmodule

// File: tb/tb_cfg_addr_seq_6bit.sv
// Directed bench for cfg_addr_seq_6bit. The bench provides the external
// 6-bit adder and the write consumer. Inputs are driven 1 time unit after a
// rising edge. Outputs are observed at that same point. Accepted beats are
// counted on the falling edge.
module tb_cfg_addr_seq_6bit;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   beats;

    cfg_addr_seq_6bit_if bus ();

    // The downstream carry-lookahead adder: plain modulo-64 sum
    assign bus.add_sum = bus.add_a + bus.add_b;

    cfg_addr_seq_6bit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count accepted beats midway between rising edges
    always @(negedge clk) begin
        if (bus.wr_valid && bus.wr_ready) beats++;
    end

    // Observed vector: {wr_valid, busy, done, wr_addr, add_a, add_b}
    function automatic logic [20:0] snap();
        return {bus.wr_valid, bus.busy, bus.done, bus.wr_addr, bus.add_a, bus.add_b};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_seq(input logic [5:0] b, input logic [5:0] s, input logic [5:0] c);
        bus.start  = 1'b1;
        bus.base   = b;
        bus.stride = s;
        bus.count  = c;
        beats      = 0;
        step();
        bus.start  = 1'b0;
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.base     = 6'd0;
        bus.stride   = 6'd0;
        bus.count    = 6'd0;
        bus.wr_ready = 1'b1;
        #1;
        checks++;
        if (snap() !== 21'd0) begin
            errors++; $display("FAIL reset_outputs got=%h exp=%h", snap(), 21'd0);
        end
        step();
        step();
        rst = 1'b0;
        step();
        checks++;
        if (snap() !== 21'd0) begin
            errors++; $display("FAIL reset_idle got=%h exp=%h", snap(), 21'd0);
        end
    endtask

    task automatic test_basic();
        logic [5:0] exp_addr [4] = '{6'd5, 6'd8, 6'd11, 6'd14};
        start_seq(6'd5, 6'd3, 6'd4);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (snap() !== {3'b110, exp_addr[i], exp_addr[i], 6'd3}) begin
                errors++; $display("FAIL basic_beat%0d got=%h exp=%h", i, snap(), {3'b110, exp_addr[i], exp_addr[i], 6'd3});
            end
            step();
        end
        checks++;
        if (snap() !== {3'b001, 6'd17, 6'd17, 6'd3}) begin
            errors++; $display("FAIL basic_done got=%h exp=%h", snap(), {3'b001, 6'd17, 6'd17, 6'd3});
        end
        checks++;
        if (beats !== 4) begin
            errors++; $display("FAIL basic_beats got=%0d exp=4", beats);
        end
        step();
        checks++;
        if (snap() !== {3'b000, 6'd17, 6'd17, 6'd3}) begin
            errors++; $display("FAIL basic_idle got=%h exp=%h", snap(), {3'b000, 6'd17, 6'd17, 6'd3});
        end
    endtask

    task automatic test_wrap();
        logic [5:0] exp_addr [3] = '{6'd62, 6'd1, 6'd4};
        start_seq(6'd62, 6'd3, 6'd3);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (snap() !== {3'b110, exp_addr[i], exp_addr[i], 6'd3}) begin
                errors++; $display("FAIL wrap_beat%0d got=%h exp=%h", i, snap(), {3'b110, exp_addr[i], exp_addr[i], 6'd3});
            end
            step();
        end
        checks++;
        if (snap() !== {3'b001, 6'd7, 6'd7, 6'd3}) begin
            errors++; $display("FAIL wrap_done got=%h exp=%h", snap(), {3'b001, 6'd7, 6'd7, 6'd3});
        end
        checks++;
        if (beats !== 3) begin
            errors++; $display("FAIL wrap_beats got=%0d exp=3", beats);
        end
        step();
    endtask

    task automatic test_count_zero();
        logic [5:0] e;
        start_seq(6'd0, 6'd1, 6'd0);
        for (int i = 0; i < 64; i++) begin
            e = 6'(i);
            checks++;
            if (snap() !== {3'b110, e, e, 6'd1}) begin
                errors++; $display("FAIL count0_beat%0d got=%h exp=%h", i, snap(), {3'b110, e, e, 6'd1});
            end
            step();
        end
        checks++;
        if (snap() !== {3'b001, 6'd0, 6'd0, 6'd1}) begin
            errors++; $display("FAIL count0_done got=%h exp=%h", snap(), {3'b001, 6'd0, 6'd0, 6'd1});
        end
        checks++;
        if (beats !== 64) begin
            errors++; $display("FAIL count0_beats got=%0d exp=64", beats);
        end
        step();
    endtask

    task automatic test_backpressure();
        start_seq(6'd10, 6'd2, 6'd3);
        checks++;
        if (snap() !== {3'b110, 6'd10, 6'd10, 6'd2}) begin
            errors++; $display("FAIL bp_beat0 got=%h exp=%h", snap(), {3'b110, 6'd10, 6'd10, 6'd2});
        end
        step();
        bus.wr_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (snap() !== {3'b110, 6'd12, 6'd12, 6'd2}) begin
                errors++; $display("FAIL bp_hold%0d got=%h exp=%h", k, snap(), {3'b110, 6'd12, 6'd12, 6'd2});
            end
            step();
        end
        bus.wr_ready = 1'b1;
        checks++;
        if (snap() !== {3'b110, 6'd12, 6'd12, 6'd2}) begin
            errors++; $display("FAIL bp_beat1 got=%h exp=%h", snap(), {3'b110, 6'd12, 6'd12, 6'd2});
        end
        step();
        checks++;
        if (snap() !== {3'b110, 6'd14, 6'd14, 6'd2}) begin
            errors++; $display("FAIL bp_beat2 got=%h exp=%h", snap(), {3'b110, 6'd14, 6'd14, 6'd2});
        end
        step();
        checks++;
        if (snap() !== {3'b001, 6'd16, 6'd16, 6'd2}) begin
            errors++; $display("FAIL bp_done got=%h exp=%h", snap(), {3'b001, 6'd16, 6'd16, 6'd2});
        end
        checks++;
        if (beats !== 3) begin
            errors++; $display("FAIL bp_beats got=%0d exp=3", beats);
        end
        step();
    endtask

    task automatic test_ignored_start();
        logic [5:0] e;
        start_seq(6'd5, 6'd1, 6'd3);
        step();
        // Beat 2: raise start with new operands while running
        bus.start  = 1'b1;
        bus.base   = 6'd40;
        bus.stride = 6'd7;
        bus.count  = 6'd9;
        checks++;
        if (snap() !== {3'b110, 6'd6, 6'd6, 6'd1}) begin
            errors++; $display("FAIL ign_beat1 got=%h exp=%h", snap(), {3'b110, 6'd6, 6'd6, 6'd1});
        end
        step();
        checks++;
        if (snap() !== {3'b110, 6'd7, 6'd7, 6'd1}) begin
            errors++; $display("FAIL ign_beat2 got=%h exp=%h", snap(), {3'b110, 6'd7, 6'd7, 6'd1});
        end
        step();
        checks++;
        if (snap() !== {3'b001, 6'd8, 6'd8, 6'd1}) begin
            errors++; $display("FAIL ign_done got=%h exp=%h", snap(), {3'b001, 6'd8, 6'd8, 6'd1});
        end
        checks++;
        if (beats !== 3) begin
            errors++; $display("FAIL ign_beats got=%0d exp=3", beats);
        end
        step();
        // start was high at the DONE edge: must land in IDLE, not RUN
        checks++;
        if (snap() !== {3'b000, 6'd8, 6'd8, 6'd1}) begin
            errors++; $display("FAIL ign_idle got=%h exp=%h", snap(), {3'b000, 6'd8, 6'd8, 6'd1});
        end
        bus.start = 1'b0;
        step();
        checks++;
        if (snap() !== {3'b000, 6'd8, 6'd8, 6'd1}) begin
            errors++; $display("FAIL ign_idle2 got=%h exp=%h", snap(), {3'b000, 6'd8, 6'd8, 6'd1});
        end
        // A start seen in IDLE now takes the new operands
        start_seq(6'd40, 6'd7, 6'd9);
        for (int i = 0; i < 9; i++) begin
            e = 6'((40 + 7 * i) % 64);
            checks++;
            if (snap() !== {3'b110, e, e, 6'd7}) begin
                errors++; $display("FAIL ign_new_beat%0d got=%h exp=%h", i, snap(), {3'b110, e, e, 6'd7});
            end
            step();
        end
        checks++;
        if (snap() !== {3'b001, 6'd39, 6'd39, 6'd7}) begin
            errors++; $display("FAIL ign_new_done got=%h exp=%h", snap(), {3'b001, 6'd39, 6'd39, 6'd7});
        end
        step();
    endtask

    task automatic test_reset_mid_run();
        start_seq(6'd20, 6'd4, 6'd5);
        step();
        checks++;
        if (snap() !== {3'b110, 6'd24, 6'd24, 6'd4}) begin
            errors++; $display("FAIL rstrun_beat1 got=%h exp=%h", snap(), {3'b110, 6'd24, 6'd24, 6'd4});
        end
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (snap() !== 21'd0) begin
            errors++; $display("FAIL rstrun_async got=%h exp=%h", snap(), 21'd0);
        end
        step();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            checks++;
            if (snap() !== 21'd0) begin
                errors++; $display("FAIL rstrun_idle%0d got=%h exp=%h", k, snap(), 21'd0);
            end
        end
        checks++;
        if (beats !== 1) begin
            errors++; $display("FAIL rstrun_beats got=%0d exp=1", beats);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        beats  = 0;
        test_reset();
        test_basic();
        test_wrap();
        test_count_zero();
        test_backpressure();
        test_ignored_start();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
